// File: rtl/c_encode_serial.sv
// rtl/c_encode_serial.sv - serialises a multi-hot request vector into offset-adjusted indices
// One beat per set bit, rotating-priority scan, last-beat marker on the final set bit.
module c_encode_serial #(
  parameter int num_ports = 8,
  parameter int offset    = 0,
  parameter bit rr_mode   = 1'b0,
  localparam int width    = (num_ports > 1) ? $clog2(num_ports) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [0:num_ports-1] in_vector,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [0:width-1]     out_index,
  output logic                 out_last
);

  localparam int off_mod = ((offset % num_ports) + num_ports) % num_ports;
  localparam logic [width-1:0] last_pos = width'(num_ports - 1);
  localparam logic [width:0]   ports_w  = (width+1)'(num_ports);
  localparam logic [width:0]   off_w    = (width+1)'(off_mod);

  logic [0:num_ports-1] pend;
  logic [width-1:0]     ptr;

  logic                 accept;
  logic                 pop;
  logic [0:num_ports-1] scan_vec;
  logic [0:num_ports-1] scan_rest;
  logic [width-1:0]     scan_start;
  logic [width-1:0]     scan_pos;
  logic [width-1:0]     hi_pos;
  logic [width-1:0]     lo_pos;
  logic                 hi_found;
  logic [width-1:0]     ptr_next;
  logic [width:0]       idx_sum;
  logic [width-1:0]     index_next;

  assign in_ready = ~out_valid | (out_ready & out_last);

  always_comb begin
    accept     = in_valid & in_ready;
    pop        = out_valid & out_ready;
    scan_vec   = accept ? in_vector : pend;
    scan_start = (accept && !rr_mode) ? '0 : ptr;

    // Lowest set bit at or after the start wins; otherwise wrap to the lowest set bit.
    hi_pos   = '0;
    lo_pos   = '0;
    hi_found = 1'b0;
    for (int i = num_ports - 1; i >= 0; i--) begin
      if (scan_vec[i]) begin
        lo_pos = width'(i);
        if (i >= int'(scan_start)) begin
          hi_pos   = width'(i);
          hi_found = 1'b1;
        end
      end
    end
    scan_pos = hi_found ? hi_pos : lo_pos;

    scan_rest           = scan_vec;
    scan_rest[scan_pos] = 1'b0;

    ptr_next = (scan_pos == last_pos) ? '0 : scan_pos + 1'b1;

    idx_sum = {1'b0, scan_pos} + off_w;
    if (idx_sum >= ports_w) begin
      idx_sum = idx_sum - ports_w;
    end
    index_next = idx_sum[width-1:0];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pend      <= '0;
      ptr       <= '0;
      out_valid <= 1'b0;
      out_index <= '0;
      out_last  <= 1'b0;
    end else if ((accept && (|in_vector)) || (pop && (|pend))) begin
      out_valid <= 1'b1;
      out_index <= index_next;
      out_last  <= ~(|scan_rest);
      pend      <= scan_rest;
      ptr       <= ptr_next;
    end else if (pop) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_c_encode_serial.sv
// tb/tb_c_encode_serial.sv - directed scoreboard bench for c_encode_serial
// Three instances: ascending scan, ascending scan with offset 3, round-robin scan.
module tb_c_encode_serial;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid  [3];
  logic       in_ready  [3];
  logic [0:7] in_vector [3];
  logic       out_valid [3];
  logic       out_ready [3];
  logic [0:2] out_index [3];
  logic       out_last  [3];

  int         n_checks = 0;
  int         n_pass   = 0;
  int         cyc_cnt  = 0;
  int         mptr [3];
  logic [5:0] exp_q [$];
  int         a0, a1;

  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  c_encode_serial #(.num_ports(8), .offset(0), .rr_mode(1'b0)) u_asc (
    .clk(clk), .reset(reset),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_vector(in_vector[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .out_index(out_index[0]), .out_last(out_last[0])
  );

  c_encode_serial #(.num_ports(8), .offset(3), .rr_mode(1'b0)) u_off (
    .clk(clk), .reset(reset),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_vector(in_vector[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .out_index(out_index[1]), .out_last(out_last[1])
  );

  c_encode_serial #(.num_ports(8), .offset(0), .rr_mode(1'b1)) u_rr (
    .clk(clk), .reset(reset),
    .in_valid(in_valid[2]), .in_ready(in_ready[2]), .in_vector(in_vector[2]),
    .out_valid(out_valid[2]), .out_ready(out_ready[2]),
    .out_index(out_index[2]), .out_last(out_last[2])
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Reference order: walk positions upward from the start pointer, wrapping at 8.
  task automatic model_push(input int d, input logic [0:7] v);
    logic [0:7] pend;
    int         off;
    int         cur;
    int         p;
    pend = v;
    off  = (d == 1) ? 3 : 0;
    cur  = (d == 2) ? mptr[d] : 0;
    while (pend != 8'b0) begin
      p = 0;
      for (int k = 0; k < 8; k++) begin
        if (pend[(cur + k) % 8]) begin
          p = (cur + k) % 8;
          break;
        end
      end
      pend[p] = 1'b0;
      exp_q.push_back({2'(d), 3'((p + off) % 8), (pend == 8'b0)});
      cur = (p + 1) % 8;
    end
    if (v != 8'b0) mptr[d] = cur;
  endtask

  task automatic send(input int d, input logic [0:7] v, output int acc);
    bit ok;
    ok           = 1'b0;
    acc          = -1;
    in_valid[d]  = 1'b1;
    in_vector[d] = v;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      ok = in_ready[d];
      @(posedge clk);
      #1;
    end
    in_valid[d]  = 1'b0;
    in_vector[d] = '0;
    chk($sformatf("accept_d%0d", d), ok, 1);
    if (ok) begin
      acc = cyc_cnt;
      model_push(d, v);
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) cyc(1);
    cyc(1);
    chk("drain", exp_q.size(), 0);
  endtask

  // Beats are consumed on the next rising edge when valid and ready are both high here.
  always @(negedge clk) begin
    for (int d = 0; d < 3; d++) begin
      if (out_valid[d] === 1'b1 && out_ready[d] === 1'b1) begin
        chk($sformatf("beat_expected_d%0d", d), exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          chk($sformatf("beat_d%0d", d), {2'(d), out_index[d], out_last[d]}, exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    reset = 1'b0;
    for (int d = 0; d < 3; d++) begin
      in_valid[d]  = 1'b0;
      in_vector[d] = '0;
      out_ready[d] = 1'b1;
      mptr[d]      = 0;
    end
    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("rst_valid_d%0d", d), out_valid[d], 0);
      chk($sformatf("rst_index_d%0d", d), out_index[d], 0);
      chk($sformatf("rst_last_d%0d", d), out_last[d], 0);
      chk($sformatf("rst_ready_d%0d", d), in_ready[d], 1);
    end
    reset = 1'b1;
    cyc(1);

    send(0, 8'b10000001, a0);
    chk("t1_c1_valid", out_valid[0], 1);
    chk("t1_c1_index", out_index[0], 0);
    chk("t1_c1_last", out_last[0], 0);
    cyc(1);
    chk("t1_c2_index", out_index[0], 7);
    chk("t1_c2_last", out_last[0], 1);
    chk("t1_c2_in_ready", in_ready[0], 1);
    cyc(1);
    chk("t1_idle", out_valid[0], 0);

    for (int t = 0; t < 8; t++) begin
      logic [0:7] v;
      v    = '0;
      v[t] = 1'b1;
      send(1, v, a0);
      chk($sformatf("walk_index_%0d", t), out_index[1], (t + 3) % 8);
      chk($sformatf("walk_last_%0d", t), out_last[1], 1);
    end
    drain();

    out_ready[0] = 1'b0;
    send(0, 8'b01100000, a0);
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", out_valid[0], 1);
      chk("bp_index", out_index[0], 1);
      chk("bp_last", out_last[0], 0);
      chk("bp_in_ready", in_ready[0], 0);
      cyc(1);
    end
    out_ready[0] = 1'b1;
    cyc(1);
    chk("bp_rel_index", out_index[0], 2);
    chk("bp_rel_last", out_last[0], 1);
    drain();

    send(2, 8'b11110000, a0);
    send(2, 8'b11000001, a1);
    chk("rr_b2b_gap", a1 - a0, 4);
    chk("rr_second_first", out_index[2], 7);
    drain();

    send(2, 8'b00000000, a0);
    chk("zero_valid", out_valid[2], 0);
    chk("zero_in_ready", in_ready[2], 1);
    send(2, 8'b00000000, a1);
    chk("zero_rate", a1 - a0, 1);
    send(2, 8'b10100000, a0);
    chk("zero_ptr_kept", out_index[2], 2);
    drain();

    send(2, 8'b11100000, a0);
    chk("pre_rst_first", out_index[2], 1);
    #2;
    reset = 1'b0;
    #1;
    chk("rst_async_valid", out_valid[2], 0);
    chk("rst_async_in_ready", in_ready[2], 1);
    exp_q.delete();
    for (int d = 0; d < 3; d++) mptr[d] = 0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    cyc(1);
    send(2, 8'b10100000, a0);
    chk("post_rst_ptr", out_index[2], 0);
    drain();
    send(2, 8'b00100000, a0);
    chk("post_rst_index", out_index[2], 2);
    chk("post_rst_last", out_last[2], 1);
    drain();

    chk("sb_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
